// File: rtl/apb4_gpio_irq_if.sv
// ---------------------------------------------------------------------------
// apb4_gpio_irq_if : APB4 bus bundle for the apb4_gpio_irq peripheral.
//   master modport : drives PSEL/PENABLE/PWRITE/PSTRB/PADDR/PWDATA,
//                    receives PRDATA/PREADY/PSLVERR.
//   slave modport  : the mirror image, used by the peripheral.
// ---------------------------------------------------------------------------
interface apb4_gpio_irq_if #(
   parameter int PDATA_SIZE = 32,
   parameter int PADDR_SIZE = 6
);
   logic                    PSEL;
   logic                    PENABLE;
   logic                    PWRITE;
   logic [PDATA_SIZE/8-1:0] PSTRB;
   logic [PADDR_SIZE-1:0]   PADDR;
   logic [PDATA_SIZE-1:0]   PWDATA;
   logic [PDATA_SIZE-1:0]   PRDATA;
   logic                    PREADY;
   logic                    PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PSTRB, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PSTRB, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb4_gpio_irq.sv
// ---------------------------------------------------------------------------
// apb4_gpio_irq : APB4 GPIO peripheral with per-pin edge/level interrupts.
//   PCLK, PRESETn : clock, asynchronous active-low reset
//   apb           : APB4 slave port (zero wait states, PSLVERR on unmapped
//                   offsets and on writes to IN)
//   irq_o         : registered OR of (IRQ_STATUS & IRQ_EN)
//   gpio_i        : asynchronous pin inputs
//   gpio_o/gpio_oe: pin output values / output enables
// Register map: 0x00 DIR, 0x04 OUT, 0x08 IN, 0x0C IRQ_EN, 0x10 IRQ_TYPE,
//   0x14 IRQ_POL, 0x18 IRQ_STATUS (W1C), 0x1C OUT_TGL (WO, reads 0).
// Optional build macro APB4_GPIO_IRQ_DEBOUNCE_EN adds 0x20 DEB_EN and a
//   per-pin debounce counter in front of IN.
// ---------------------------------------------------------------------------
module apb4_gpio_irq #(
   parameter int PDATA_SIZE   = 32,
   parameter int PADDR_SIZE   = 6,
   parameter int GPIO_WIDTH   = 32,
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CYC = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   apb4_gpio_irq_if.slave        apb,
   output logic                  irq_o,
   input  logic [GPIO_WIDTH-1:0] gpio_i,
   output logic [GPIO_WIDTH-1:0] gpio_o,
   output logic [GPIO_WIDTH-1:0] gpio_oe
);
   localparam logic [3:0] A_DIR = 4'd0, A_OUT = 4'd1, A_IN  = 4'd2, A_EN  = 4'd3,
                          A_TYP = 4'd4, A_POL = 4'd5, A_STA = 4'd6, A_TGL = 4'd7,
                          A_DEB = 4'd8;

   logic [GPIO_WIDTH-1:0] dir_r, out_r, en_r, typ_r, pol_r, sta_r, prev_r;
   logic [GPIO_WIDTH-1:0] in_val, sync_out, gm, wval, w1c, rise, fall, edge_ev, ev;
   logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] sync_q;
   logic [PDATA_SIZE-1:0] bm;
   logic [2:0]            mask_cnt;
   logic [3:0]            idx;
   logic                  access, mapped, err, wr_ok;
   logic                  unused_bits;

   // ---------------- decode ----------------
   assign idx    = apb.PADDR[5:2];
   assign access = apb.PSEL & apb.PENABLE;
`ifdef APB4_GPIO_IRQ_DEBOUNCE_EN
   assign mapped = (idx <= A_DEB);
`else
   assign mapped = (idx <= A_TGL);
`endif
   assign err   = ~mapped | (apb.PWRITE & (idx == A_IN));
   assign wr_ok = access & apb.PWRITE & ~err;

   always_comb begin
      bm = '0;
      for (int b = 0; b < PDATA_SIZE/8; b++)
         bm[b*8 +: 8] = {8{apb.PSTRB[b]}};
   end
   assign gm   = bm[GPIO_WIDTH-1:0];
   assign wval = apb.PWDATA[GPIO_WIDTH-1:0] & gm;
   assign w1c  = (wr_ok && idx == A_STA) ? wval : '0;

   assign apb.PREADY  = 1'b1;
   assign apb.PSLVERR = access & err;
   assign gpio_o      = out_r;
   assign gpio_oe     = dir_r;
   assign unused_bits = ^{apb.PADDR, apb.PWDATA};

   // ---------------- input path ----------------
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
   end
   assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef APB4_GPIO_IRQ_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
   logic [GPIO_WIDTH-1:0]         deb_en_r, deb_q;
   logic [GPIO_WIDTH-1:0][CW-1:0] deb_cnt;

   // deb_q tracks the synchroniser while a pin is not debounced, so enabling
   // debounce never causes a spurious IN transition.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         deb_q   <= '0;
         deb_cnt <= '0;
      end else begin
         for (int i = 0; i < GPIO_WIDTH; i++) begin
            if (!deb_en_r[i] || sync_out[i] == deb_q[i]) begin
               deb_q[i]   <= sync_out[i];
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == CW'(DEBOUNCE_CYC-1)) begin
               deb_q[i]   <= sync_out[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end
   assign in_val = (deb_en_r & deb_q) | (~deb_en_r & sync_out);
`else
   assign in_val = sync_out;
`endif

   // ---------------- events ----------------
   assign rise    = in_val & ~prev_r;
   assign fall    = ~in_val & prev_r;
   // edge events are masked until the synchroniser has flushed its reset zeros
   assign edge_ev = (mask_cnt != 3'd0) ? '0 : ((pol_r & rise) | (~pol_r & fall));
   assign ev      = (typ_r & edge_ev) | (~typ_r & ~(in_val ^ pol_r));

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         prev_r   <= '0;
         mask_cnt <= 3'(SYNC_STAGES + 1);
         sta_r    <= '0;
         irq_o    <= 1'b0;
      end else begin
         prev_r <= in_val;
         if (mask_cnt != 3'd0) mask_cnt <= mask_cnt - 3'd1;
         sta_r  <= (sta_r & ~w1c) | ev;   // set wins over W1C
         irq_o  <= |(sta_r & en_r);
      end
   end

   // ---------------- register writes ----------------
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         dir_r <= '0;
         out_r <= '0;
         en_r  <= '0;
         typ_r <= '0;
         pol_r <= '0;
`ifdef APB4_GPIO_IRQ_DEBOUNCE_EN
         deb_en_r <= '0;
`endif
      end else if (wr_ok) begin
         case (idx)
            A_DIR: dir_r <= (dir_r & ~gm) | wval;
            A_OUT: out_r <= (out_r & ~gm) | wval;
            A_EN:  en_r  <= (en_r  & ~gm) | wval;
            A_TYP: typ_r <= (typ_r & ~gm) | wval;
            A_POL: pol_r <= (pol_r & ~gm) | wval;
            A_TGL: out_r <= out_r ^ wval;
`ifdef APB4_GPIO_IRQ_DEBOUNCE_EN
            A_DEB: deb_en_r <= (deb_en_r & ~gm) | wval;
`endif
            default: ;
         endcase
      end
   end

   // ---------------- read mux ----------------
   always_comb begin
      logic [GPIO_WIDTH-1:0] rd;
      rd = '0;
      case (idx)
         A_DIR: rd = dir_r;
         A_OUT: rd = out_r;
         A_IN:  rd = in_val;
         A_EN:  rd = en_r;
         A_TYP: rd = typ_r;
         A_POL: rd = pol_r;
         A_STA: rd = sta_r;
`ifdef APB4_GPIO_IRQ_DEBOUNCE_EN
         A_DEB: rd = deb_en_r;
`endif
         default: rd = '0;
      endcase
      apb.PRDATA = '0;
      if (access && !apb.PWRITE)
         apb.PRDATA[GPIO_WIDTH-1:0] = rd;
   end
endmodule

// File: tb/tb_apb4_gpio_irq.sv
module tb_apb4_gpio_irq;
   localparam int GW = 32;

   typedef struct {
      logic        is_rd;
      logic [31:0] rdata;
      logic        err;
      string       name;
   } apb_exp_t;

   typedef struct {
      logic [31:0] o;
      logic [31:0] oe;
      logic        irq;
      string       name;
   } pin_exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          irq;
   logic [GW-1:0] gpio_i = '0;
   logic [GW-1:0] gpio_o, gpio_oe;
   logic          pin_req = 1'b0;

   apb_exp_t apb_q[$];
   pin_exp_t pin_q[$];
   apb_exp_t ae;
   pin_exp_t pe;
   int checks = 0;
   int errors = 0;

   apb4_gpio_irq_if #(.PDATA_SIZE(32), .PADDR_SIZE(6)) bus();

   apb4_gpio_irq #(
      .PDATA_SIZE(32), .PADDR_SIZE(6), .GPIO_WIDTH(GW),
      .SYNC_STAGES(2), .DEBOUNCE_CYC(16)
   ) dut (
      .PCLK(clk), .PRESETn(rst_n), .apb(bus), .irq_o(irq),
      .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe)
   );

   always #5 clk = ~clk;

   // monitor: pops an expectation whenever the DUT presents an access phase
   // or the stimulus flags a pin sample point
   always @(negedge clk) begin
      if (rst_n && bus.PSEL && bus.PENABLE) begin
         checks++;
         if (apb_q.size() == 0) begin
            errors++;
            $display("FAIL apb_unexpected: access with no expectation queued");
         end else begin
            ae = apb_q.pop_front();
            if (bus.PSLVERR !== ae.err || (ae.is_rd && bus.PRDATA !== ae.rdata)) begin
               errors++;
               $display("FAIL %s: got rdata=%h err=%b, want rdata=%h err=%b (rd=%b)",
                        ae.name, bus.PRDATA, bus.PSLVERR, ae.rdata, ae.err, ae.is_rd);
            end
         end
      end
      if (pin_req) begin
         checks++;
         if (pin_q.size() == 0) begin
            errors++;
            $display("FAIL pin_unexpected: sample with no expectation queued");
         end else begin
            pe = pin_q.pop_front();
            if (gpio_o !== pe.o || gpio_oe !== pe.oe || irq !== pe.irq || bus.PREADY !== 1'b1) begin
               errors++;
               $display("FAIL %s: got o=%h oe=%h irq=%b ready=%b, want o=%h oe=%h irq=%b ready=1",
                        pe.name, gpio_o, gpio_oe, irq, bus.PREADY, pe.o, pe.oe, pe.irq);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic apb_xfer(input logic wr, input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [31:0] exp_rd,
                           input logic exp_err, input string name);
      apb_q.push_back('{is_rd: ~wr, rdata: exp_rd, err: exp_err, name: name});
      @(posedge clk); #1;
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
      bus.PADDR = addr; bus.PWDATA = data; bus.PSTRB = strb;
      @(posedge clk); #1;
      bus.PENABLE = 1'b1;
      @(posedge clk); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d, input string n);
      apb_xfer(1'b1, a, d, 4'hF, 32'h0, 1'b0, n);
   endtask

   task automatic rd(input logic [5:0] a, input logic [31:0] e, input string n);
      apb_xfer(1'b0, a, 32'h0, 4'h0, e, 1'b0, n);
   endtask

   task automatic chk_pins(input logic [31:0] o, input logic [31:0] oe, input logic i, input string n);
      pin_q.push_back('{o: o, oe: oe, irq: i, name: n});
      pin_req = 1'b1;
      @(posedge clk); #1;
      pin_req = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
      bus.PADDR = '0; bus.PWDATA = '0; bus.PSTRB = '0;
      cyc(1);
      do_reset();
      chk_pins(32'h0, 32'h0, 1'b0, "reset_pins");
      rd(6'h00, 32'h0, "reset_dir");
      rd(6'h0C, 32'h0, "reset_en");

      // outputs and atomic toggle
      wr(6'h00, 32'hFF, "wr_dir");
      wr(6'h04, 32'hA5, "wr_out");
      chk_pins(32'hA5, 32'hFF, 1'b0, "pins_a5");
      wr(6'h1C, 32'h0F, "wr_tgl");
      chk_pins(32'hAA, 32'hFF, 1'b0, "pins_tgl");
      rd(6'h1C, 32'h0, "rd_tgl_zero");
      rd(6'h04, 32'hAA, "rd_out_aa");

      // all pins edge/rising, clear reset-time level status
      wr(6'h10, 32'hFFFF_FFFF, "wr_type");
      wr(6'h14, 32'hFFFF_FFFF, "wr_pol");
      wr(6'h18, 32'hFFFF_FFFF, "w1c_all");
      rd(6'h18, 32'h0, "sta_clear");

      // rising edge on pin 3 -> irq after SYNC_STAGES+2 edges
      wr(6'h0C, 32'h08, "wr_en3");
      gpio_i[3] = 1'b1;
      cyc(3);
      chk_pins(32'hAA, 32'hFF, 1'b0, "irq_edge3_low");
      chk_pins(32'hAA, 32'hFF, 1'b1, "irq_edge4_high");
      rd(6'h18, 32'h08, "sta_pin3");
      wr(6'h18, 32'h08, "w1c_pin3");
      chk_pins(32'hAA, 32'hFF, 1'b1, "irq_w1c_same");
      chk_pins(32'hAA, 32'hFF, 1'b0, "irq_w1c_next");
      rd(6'h18, 32'h0, "sta_no_reset");

      // level-low on pin 0 re-sets after W1C while the level persists
      wr(6'h10, 32'hFFFF_FFFE, "wr_type_lvl0");
      wr(6'h14, 32'hFFFF_FFFE, "wr_pol_low0");
      wr(6'h18, 32'h01, "w1c_lvl0");
      rd(6'h18, 32'h01, "sta_lvl_reset");
      gpio_i[0] = 1'b1;
      cyc(4);
      wr(6'h18, 32'h01, "w1c_lvl0_final");
      rd(6'h18, 32'h0, "sta_lvl_clear");

      // strobes, errors, no side effects
      apb_xfer(1'b1, 6'h04, 32'hFFFF_FFFF, 4'b0001, 32'h0, 1'b0, "wr_out_strb");
      rd(6'h04, 32'hFF, "rd_out_strb");
      chk_pins(32'hFF, 32'hFF, 1'b0, "pins_strb");
      apb_xfer(1'b1, 6'h08, 32'h0, 4'hF, 32'h0, 1'b1, "err_wr_in");
      apb_xfer(1'b1, 6'h3C, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "err_wr_3c");
      apb_xfer(1'b0, 6'h24, 32'h0, 4'h0, 32'h0, 1'b1, "err_rd_24");
`ifndef APB4_GPIO_IRQ_DEBOUNCE_EN
      apb_xfer(1'b1, 6'h20, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "err_wr_20");
`endif
      rd(6'h04, 32'hFF, "rd_out_after_err");
      rd(6'h00, 32'hFF, "rd_dir_after_err");
      rd(6'h08, 32'h09, "rd_in");

      // power-up edge mask: pins high through reset release
      gpio_i = 32'hFFFF_FFFF;
      do_reset();
      chk_pins(32'h0, 32'h0, 1'b0, "reset2_pins");
      rd(6'h04, 32'h0, "reset2_out");
      rd(6'h08, 32'hFFFF_FFFF, "reset2_in");
      wr(6'h10, 32'hFFFF_FFFF, "wr_type2");
      wr(6'h14, 32'hFFFF_FFFF, "wr_pol2");
      wr(6'h18, 32'hFFFF_FFFF, "w1c_all2");
      rd(6'h18, 32'h0, "sta_powerup");
      gpio_i[5] = 1'b0;
      cyc(4);
      rd(6'h18, 32'h0, "sta_fall5");
      gpio_i[5] = 1'b1;
      cyc(4);
      rd(6'h18, 32'h20, "sta_rise5");

`ifdef APB4_GPIO_IRQ_DEBOUNCE_EN
      wr(6'h20, 32'h02, "wr_deb");
      rd(6'h20, 32'h02, "rd_deb");
      gpio_i[1] = 1'b0;
      cyc(10);
      gpio_i[1] = 1'b1;
      cyc(30);
      rd(6'h08, 32'hFFFF_FFFF, "deb_glitch");
      gpio_i[1] = 1'b0;
      cyc(10);
      rd(6'h08, 32'hFFFF_FFFF, "deb_pending");
      cyc(20);
      rd(6'h08, 32'hFFFF_FFFD, "deb_settled");
`endif

      cyc(3);
      if (apb_q.size() != 0 || pin_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL leftover: got %0d apb / %0d pin unconsumed, want 0 / 0",
                  apb_q.size(), pin_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
